dsp_mac_pipelined: RTL

//  Parametrised successor to the fixed 4-bit input-registered DSP test block.

---
 rtl/dsp_pkg.sv | 15 +
 rtl/dsp_pipe_reg.sv | 32 +++
 rtl/dsp_mac_pipelined.sv | 123 ++++++++++++
 3 files changed

// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP multiply / multiply-accumulate primitive.
package dsp_pkg;

  // Mode encodings carried on the m input.
  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_MAC = 1'b1;

  // Legal parameter combination check for dsp_mac_pipelined.
  function automatic bit params_ok(int unsigned data_width, int unsigned acc_width,
                                   int unsigned in_stages, int unsigned out_reg);
    return (data_width >= 2) && (data_width % 2 == 0) && (acc_width >= data_width) &&
           (in_stages <= 4) && (out_reg <= 1);
  endfunction

endpackage

// File: rtl/dsp_pipe_reg.sv
// W-bit delay line with clock enable and synchronous active-low reset.
// DEPTH=0 degenerates to a plain wire.
module dsp_pipe_reg #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_regs
    logic [W-1:0] stage_q [DEPTH];

    // Shift the word one stage per enabled cycle; reset empties the line.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
      end else if (ce) begin
        stage_q[0] <= d;
        for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/dsp_mac_pipelined.sv
// Unsigned multiply / multiply-accumulate with configurable input pipeline,
// self-fed accumulator, optional output register, valid tracking and sticky overflow.
module dsp_mac_pipelined
  import dsp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ACC_WIDTH  = 8,
  parameter int unsigned IN_STAGES  = 1,
  parameter int unsigned OUT_REG    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH/2-1:0] a,
  input  logic [DATA_WIDTH/2-1:0] b,
  input  logic                    m,
  input  logic                    acc_clr,
  output logic                    out_valid,
  output logic [ACC_WIDTH-1:0]    out,
  output logic                    overflow
);

  localparam int unsigned HALF   = DATA_WIDTH / 2;
  localparam int unsigned WORD_W = 2 * HALF + 3;

  if (!params_ok(DATA_WIDTH, ACC_WIDTH, IN_STAGES, OUT_REG)) begin : g_bad_params
    $error("dsp_mac_pipelined: illegal parameter combination");
  end

  // Input stages: all beat fields travel together as one word.
  logic [WORD_W-1:0] in_word;
  logic [WORD_W-1:0] stg_word;
  logic              stg_valid;
  logic              stg_m;
  logic              stg_clr;
  logic [HALF-1:0]   stg_a;
  logic [HALF-1:0]   stg_b;

  assign in_word = {in_valid, m, acc_clr, a, b};

  dsp_pipe_reg #(
    .W    (WORD_W),
    .DEPTH(IN_STAGES)
  ) u_in_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .ce   (ce),
    .d    (in_word),
    .q    (stg_word)
  );

  assign {stg_valid, stg_m, stg_clr, stg_a, stg_b} = stg_word;

  // Product and accumulate datapath.
  logic [DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]  prod_ext;
  logic [ACC_WIDTH-1:0]  acc_base;
  logic [ACC_WIDTH:0]    sum;

  logic [ACC_WIDTH-1:0]  acc_q;
  logic                  acc_ovf_q;
  logic                  acc_valid_q;

  // Multiply, then add onto the (optionally cleared) accumulator with carry-out.
  always_comb begin
    prod     = {{HALF{1'b0}}, stg_a} * {{HALF{1'b0}}, stg_b};
    prod_ext = ACC_WIDTH'(prod);
    acc_base = stg_clr ? '0 : acc_q;
    sum      = {1'b0, acc_base} + {1'b0, prod_ext};
  end

  // Accumulator stage: bubbles advance the valid but leave acc and overflow alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      acc_ovf_q   <= 1'b0;
      acc_valid_q <= 1'b0;
    end else if (ce) begin
      acc_valid_q <= stg_valid;
      if (stg_valid) begin
        if (stg_m == MODE_MAC) begin
          acc_q     <= sum[ACC_WIDTH-1:0];
          // Sticky carry; acc_clr restarts it before this beat's add is folded in.
          acc_ovf_q <= (stg_clr ? 1'b0 : acc_ovf_q) | sum[ACC_WIDTH];
        end else begin
          acc_q     <= prod_ext;
          acc_ovf_q <= 1'b0;
        end
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [ACC_WIDTH-1:0] out_q;
    logic                 out_ovf_q;
    logic                 out_valid_q;

    // Output register: captures the acc stage only on valid beats so out holds otherwise.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_q       <= '0;
        out_ovf_q   <= 1'b0;
        out_valid_q <= 1'b0;
      end else if (ce) begin
        out_valid_q <= acc_valid_q;
        if (acc_valid_q) begin
          out_q     <= acc_q;
          out_ovf_q <= acc_ovf_q;
        end
      end
    end

    assign out       = out_q;
    assign overflow  = out_ovf_q;
    assign out_valid = out_valid_q;
  end else begin : g_out_direct
    assign out       = acc_q;
    assign overflow  = acc_ovf_q;
    assign out_valid = acc_valid_q;
  end

endmodule
